// File: rtl/per2bpm_avg_pkg.sv
// Shared constants, FSM encoding and width helpers for the period-to-BPM averager.
`timescale 1ns/1ps
package per2bpm_avg_pkg;

    localparam longint unsigned MIN_NS = 64'd60_000_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DIV   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic longint unsigned min_tp(input longint unsigned tp_cycle);
        return MIN_NS / tp_cycle;
    endfunction

    localparam longint unsigned DEF_MIN_TP = min_tp(64'd5120);
    localparam int DEF_PER_W = $clog2(DEF_MIN_TP + 1);
    localparam int DEF_BPM_W = $clog2(250 + 1);

endpackage

// File: rtl/per2bpm_avg_if.sv
// Period-in / BPM-out bundle between the tap counter, the averager and the display.
`timescale 1ns/1ps
interface per2bpm_avg_if
    import per2bpm_avg_pkg::*;
#(
    parameter int PER_W = DEF_PER_W,
    parameter int BPM_W = DEF_BPM_W
);
    logic [PER_W-1:0] btn_per;
    logic             btn_per_valid;
    logic             btn_per_ready;
    logic [BPM_W-1:0] bpm;
    logic             bpm_valid;
    logic             bpm_sat_hi;
    logic             bpm_sat_lo;

    modport master (
        output btn_per, btn_per_valid,
        input  btn_per_ready, bpm, bpm_valid, bpm_sat_hi, bpm_sat_lo
    );

    modport slave (
        input  btn_per, btn_per_valid,
        output btn_per_ready, bpm, bpm_valid, bpm_sat_hi, bpm_sat_lo
    );
endinterface

// File: rtl/per2bpm_avg_seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; done_o marks the final step.
`timescale 1ns/1ps
module seq_divider #(
    parameter int DVD_W = 27,
    parameter int SUM_W = 26
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [SUM_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DVD_W-1:0] quotient_o
);
    localparam int CNT_W = $clog2(DVD_W);

    logic [SUM_W-1:0] rem_q, rem_d, dvs_q, diff;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, ge;
    logic [SUM_W:0]   rem_sh;

    // Partial remainder stays below the divisor, so SUM_W bits hold it.
    always_comb begin
        rem_sh = {rem_q, dvd_q[DVD_W-1]};
        ge     = (rem_sh >= {1'b0, dvs_q});
        diff   = rem_sh[SUM_W-1:0] - dvs_q;
        rem_d  = ge ? diff : rem_sh[SUM_W-1:0];
        dvd_d  = {dvd_q[DVD_W-2:0], ge};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(DVD_W - 1);
            rem_q  <= '0;
            dvd_q  <= dividend_i;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) busy_q <= 1'b0;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == '0);
    assign quotient_o = dvd_d;
endmodule

// File: rtl/per2bpm_avg.sv
// Sliding-window tap-period averager: BPM = round(MIN_TP*n/sum), clamped with saturation flags.
//   state    | meaning
//   ST_IDLE  | ready for a period; handshake registers it
//   ST_ACCUM | update window/sum/n, launch divider (or skip on zero sum)
//   ST_DIV   | DVD_W-cycle restoring division in flight
//   ST_DONE  | one-cycle bpm_valid pulse, back to idle
`timescale 1ns/1ps
module per2bpm_avg
    import per2bpm_avg_pkg::*;
#(
    parameter int TP_CYCLE = 5120,
    parameter int BPM_MAX  = 250,
    parameter int BPM_MIN  = 30,
    parameter int AVG_LOG2 = 2,
    parameter int ROUND    = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    per2bpm_avg_if.slave bus
);
    localparam longint unsigned MIN_TP = min_tp(longint'(TP_CYCLE));
    localparam int PER_W = $clog2(MIN_TP + 1);
    localparam int BPM_W = $clog2(BPM_MAX + 1);
    localparam int SUM_W = PER_W + AVG_LOG2;
    localparam int DVD_W = PER_W + AVG_LOG2 + 1;
    localparam int N     = 1 << AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CNT_W = AVG_LOG2 + 1;

    state_e           state_q;
    logic [PER_W-1:0] per_q;
    logic [PER_W-1:0] win_q [N];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [BPM_W-1:0] bpm_q, bpm_d;
    logic             valid_q, sat_hi_q, sat_lo_q, sat_hi_d, sat_lo_d;
    logic [DVD_W-1:0] dividend, quo;
    logic             div_start, div_busy, div_done;

    always_comb begin
        if (n_q == CNT_W'(N)) begin
            sum_d = sum_q - SUM_W'(win_q[ptr_q]) + SUM_W'(per_q);
            n_d   = n_q;
        end else begin
            sum_d = sum_q + SUM_W'(per_q);
            n_d   = n_q + CNT_W'(1);
        end
        ptr_d    = (ptr_q == PTR_W'(N - 1)) ? '0 : ptr_q + PTR_W'(1);
        dividend = DVD_W'(MIN_TP) * DVD_W'(n_d)
                 + ((ROUND != 0) ? DVD_W'(sum_d >> 1) : '0);
        div_start = (state_q == ST_ACCUM) && !clear_i && (sum_d != '0) && !div_busy;
    end

    always_comb begin
        bpm_d    = quo[BPM_W-1:0];
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
        if (quo > DVD_W'(BPM_MAX)) begin
            bpm_d    = BPM_W'(BPM_MAX);
            sat_hi_d = 1'b1;
        end else if (quo < DVD_W'(BPM_MIN)) begin
            bpm_d    = BPM_W'(BPM_MIN);
            sat_lo_d = 1'b1;
        end
    end

    seq_divider #(.DVD_W(DVD_W), .SUM_W(SUM_W)) u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (div_start),
        .abort_i    (clear_i),
        .dividend_i (dividend),
        .divisor_i  (sum_d),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quo)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            per_q    <= '0;
            ptr_q    <= '0;
            n_q      <= '0;
            sum_q    <= '0;
            for (int i = 0; i < N; i++) win_q[i] <= '0;
            bpm_q    <= '0;
            valid_q  <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else if (clear_i) begin
            // Result registers deliberately hold across a flush.
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            n_q     <= '0;
            sum_q   <= '0;
            for (int i = 0; i < N; i++) win_q[i] <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.btn_per_valid) begin
                        per_q   <= bus.btn_per;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    win_q[ptr_q] <= per_q;
                    ptr_q        <= ptr_d;
                    n_q          <= n_d;
                    sum_q        <= sum_d;
                    if (sum_d == '0) begin
                        bpm_q    <= BPM_W'(BPM_MAX);
                        sat_hi_q <= 1'b1;
                        sat_lo_q <= 1'b0;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q  <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        bpm_q    <= bpm_d;
                        sat_hi_q <= sat_hi_d;
                        sat_lo_q <= sat_lo_d;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.btn_per_ready = (state_q == ST_IDLE) && !clear_i;
    assign bus.bpm           = bpm_q;
    assign bus.bpm_valid     = valid_q;
    assign bus.bpm_sat_hi    = sat_hi_q;
    assign bus.bpm_sat_lo    = sat_lo_q;
endmodule

// File: tb/tb_per2bpm_avg.sv
// Directed bench: rounding and truncating instances fed the same period stream.
`timescale 1ns/1ps
module tb_per2bpm_avg;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    per2bpm_avg_if bus_r1 ();
    per2bpm_avg_if bus_r0 ();

    per2bpm_avg #(.ROUND(1)) u_dut_r1 (.clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus_r1));
    per2bpm_avg #(.ROUND(0)) u_dut_r0 (.clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus_r0));

    typedef struct {
        logic        clr;
        logic [23:0] per;
        int          lat;
        int          b1;
        int          b0;
        logic        hi;
        logic        lo;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_per(input logic [23:0] per, input logic v);
        bus_r1.btn_per = per;       bus_r0.btn_per = per;
        bus_r1.btn_per_valid = v;   bus_r0.btn_per_valid = v;
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        #1;
        chk({tag, " ready during clear"}, bus_r1.btn_per_ready, 0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Called at a negedge with the DUTs idle or finishing.
    task automatic run_sample(input string tag, input logic [23:0] per, input int exp_lat,
                              input int exp_b1, input int exp_b0, input logic exp_hi, input logic exp_lo);
        int waited = 0;
        int lat = 0;
        bit got = 0;
        while (!bus_r1.btn_per_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " ready"}, bus_r1.btn_per_ready, 1);
        drive_per(per, 1'b1);
        @(posedge clk);
        #1;
        drive_per(per, 1'b0);
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (bus_r1.bpm_valid) got = 1;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " r0 valid"}, bus_r0.bpm_valid, 1);
        chk({tag, " bpm r1"}, bus_r1.bpm, exp_b1);
        chk({tag, " bpm r0"}, bus_r0.bpm, exp_b0);
        chk({tag, " sat_hi"}, {bus_r1.bpm_sat_hi, bus_r0.bpm_sat_hi}, {exp_hi, exp_hi});
        chk({tag, " sat_lo"}, {bus_r1.bpm_sat_lo, bus_r0.bpm_sat_lo}, {exp_lo, exp_lo});
        @(negedge clk);
        chk({tag, " valid pulse"}, bus_r1.bpm_valid, 0);
        chk({tag, " ready after"}, bus_r1.btn_per_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0]  = '{1'b0, 24'd97656,    29, 120, 120, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 24'd97656,    29, 120, 120, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 24'd46875,    29, 162, 162, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 24'd97656,    29, 120, 120, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 24'd97656,    29, 120, 120, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 24'd97656,    29, 120, 120, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 24'd97656,    29, 120, 120, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 24'd46875,    29, 138, 137, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 24'd1000,     29, 250, 250, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 24'd11718750, 29,  30,  30, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 24'd0,         2, 250, 250, 1'b1, 1'b0};

        rst_n = 1'b0;
        clear = 1'b0;
        drive_per(24'd0, 1'b0);
        #1;
        chk("reset bpm", {bus_r1.bpm, bus_r0.bpm}, 0);
        chk("reset valid/flags", {bus_r1.bpm_valid, bus_r1.bpm_sat_hi, bus_r1.bpm_sat_lo,
                                  bus_r0.bpm_valid, bus_r0.bpm_sat_hi, bus_r0.bpm_sat_lo}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", bus_r1.btn_per_ready, 1);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].clr) do_clear($sformatf("v%0d", i));
            run_sample($sformatf("v%0d", i), vecs[i].per, vecs[i].lat,
                       vecs[i].b1, vecs[i].b0, vecs[i].hi, vecs[i].lo);
        end

        // Abort mid-division: no pulse, result registers hold.
        drive_per(24'd97656, 1'b1);
        @(posedge clk);
        #1;
        drive_per(24'd97656, 1'b0);
        repeat (10) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_r1.bpm_valid || bus_r0.bpm_valid) seen = 1;
        end
        chk("abort no valid", seen, 0);
        chk("abort bpm hold", bus_r1.bpm, 250);
        chk("abort sat_hi hold", bus_r1.bpm_sat_hi, 1);

        // clear together with valid: sample dropped.
        clear = 1'b1;
        drive_per(24'd97656, 1'b1);
        #1;
        chk("clear+valid ready", {bus_r1.btn_per_ready, bus_r0.btn_per_ready}, 0);
        @(negedge clk);
        clear = 1'b0;
        drive_per(24'd0, 1'b0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_r1.bpm_valid || bus_r0.bpm_valid) seen = 1;
        end
        chk("clear+valid no valid", seen, 0);
        run_sample("post-clear n1", 24'd46875, 29, 250, 250, 1'b0, 1'b0);

        // Asynchronous reset mid-division.
        drive_per(24'd97656, 1'b1);
        @(posedge clk);
        #1;
        drive_per(24'd97656, 1'b0);
        repeat (8) @(negedge clk);
        #2.3;
        rst_n = 1'b0;
        #1;
        chk("async rst bpm", {bus_r1.bpm, bus_r0.bpm}, 0);
        chk("async rst valid/flags", {bus_r1.bpm_valid, bus_r1.bpm_sat_hi, bus_r1.bpm_sat_lo,
                                      bus_r0.bpm_valid, bus_r0.bpm_sat_hi, bus_r0.bpm_sat_lo}, 0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready first clk after rst", bus_r1.btn_per_ready, 1);
        @(negedge clk);
        run_sample("post-rst n1", 24'd46875, 29, 250, 250, 1'b0, 1'b0);
        run_sample("post-rst n2", 24'd97656, 29, 162, 162, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
